// File: rtl/obf_corruption_monitor.sv
// Corruption monitor for the XOR-key-locked ripple-carry adder: per-sample
// golden comparison plus per-key-epoch statistics reported over valid/ready.
module obf_corruption_monitor #(
  parameter int WIDTH = 16,
  parameter int KEY_W = 32,
  parameter int CNT_W = 16,
  parameter int HD_W  = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  input  logic [WIDTH-1:0]             add1_i,
  input  logic [WIDTH-1:0]             add2_i,
  input  logic [WIDTH:0]               result_i,
  input  logic [KEY_W-1:0]             key_i,
  input  logic                         epoch_close_i,
  output logic                         chk_valid_o,
  output logic                         chk_mismatch_o,
  output logic [$clog2(WIDTH+2)-1:0]   chk_hd_o,
  output logic                         report_valid_o,
  input  logic                         report_ready_i,
  output logic [KEY_W-1:0]             report_key_o,
  output logic [CNT_W-1:0]             report_samples_o,
  output logic [CNT_W-1:0]             report_mismatch_o,
  output logic [HD_W-1:0]              report_hd_o
);

  localparam int HD_CW = $clog2(WIDTH+2);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   epoch_key_q;
  logic               s1_valid_q;
  logic [WIDTH:0]     s1_result_q;
  logic [WIDTH:0]     s1_golden_q;
  logic [CNT_W-1:0]   cnt_samples_q;
  logic [CNT_W-1:0]   cnt_mismatch_q;
  logic [HD_W-1:0]    hd_sum_q;

  logic               accept;
  logic               key_differs;
  logic               pipe_empty;
  logic               report_load;
  logic               epoch_done;
  logic [WIDTH:0]     s1_diff;
  logic               s1_mismatch;
  logic [HD_CW-1:0]   s1_hd;
  logic [HD_W:0]      hd_sum_ext;

  assign accept      = sample_valid_i && sample_ready_o;
  assign key_differs = key_i != epoch_key_q;
  assign pipe_empty  = !s1_valid_q && !chk_valid_o;
  assign report_load = (state_q == DRAIN) && pipe_empty;
  assign epoch_done  = (state_q == REPORT) && report_ready_i;

  assign s1_diff     = s1_result_q ^ s1_golden_q;
  assign s1_mismatch = |s1_diff;
  assign s1_hd       = HD_CW'($countones(s1_diff));
  // One extra bit catches the carry out so the accumulator can clamp.
  assign hd_sum_ext  = {1'b0, hd_sum_q} + {{(HD_W+1-HD_CW){1'b0}}, s1_hd};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = ACCUM;
      ACCUM:  if (epoch_close_i || (sample_valid_i && key_differs)) state_d = DRAIN;
      DRAIN:  if (pipe_empty) state_d = REPORT;
      REPORT: if (report_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_ready_o = 1'b0;
    unique case (state_q)
      IDLE:    sample_ready_o = 1'b1;
      ACCUM:   sample_ready_o = !(sample_valid_i && key_differs) && !epoch_close_i;
      default: sample_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          epoch_key_q <= '0;
    else if (state_q == IDLE && accept)   epoch_key_q <= key_i;
  end

  // Stage 1 captures the locked result next to its golden sum (carry kept).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      s1_golden_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_result_q <= result_i;
        s1_golden_q <= {1'b0, add1_i} + {1'b0, add2_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_valid_o    <= 1'b0;
      chk_mismatch_o <= 1'b0;
      chk_hd_o       <= '0;
    end else begin
      chk_valid_o    <= s1_valid_q;
      chk_mismatch_o <= s1_valid_q && s1_mismatch;
      chk_hd_o       <= s1_valid_q ? s1_hd : '0;
    end
  end

  // Counters clamp at all-ones; each one freezes independently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_samples_q  <= '0;
      cnt_mismatch_q <= '0;
      hd_sum_q       <= '0;
    end else if (epoch_done) begin
      cnt_samples_q  <= '0;
      cnt_mismatch_q <= '0;
      hd_sum_q       <= '0;
    end else if (s1_valid_q) begin
      if (cnt_samples_q != '1)                 cnt_samples_q  <= cnt_samples_q + CNT_W'(1);
      if (s1_mismatch && cnt_mismatch_q != '1) cnt_mismatch_q <= cnt_mismatch_q + CNT_W'(1);
      hd_sum_q <= hd_sum_ext[HD_W] ? '1 : hd_sum_ext[HD_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      report_valid_o    <= 1'b0;
      report_key_o      <= '0;
      report_samples_o  <= '0;
      report_mismatch_o <= '0;
      report_hd_o       <= '0;
    end else if (report_load) begin
      report_valid_o    <= 1'b1;
      report_key_o      <= epoch_key_q;
      report_samples_o  <= cnt_samples_q;
      report_mismatch_o <= cnt_mismatch_q;
      report_hd_o       <= hd_sum_q;
    end else if (epoch_done) begin
      report_valid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_obf_corruption_monitor.sv
// Randomized bench for obf_corruption_monitor; a list-based epoch model
// predicts per-sample checks and per-epoch reports.
module tb_obf_corruption_monitor;

  localparam int CNT_MAX   = 65535;
  localparam int HD_MAX    = (1 << 24) - 1;
  localparam int S_CNT_MAX = 15;
  localparam int S_HD_MAX  = 63;
  localparam logic [31:0] KEY_A = 32'hBDD1C4EF;
  localparam logic [31:0] KEY_B = 32'hF17B035B;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] add1 = '0, add2 = '0;
  logic [16:0] result = '0;
  logic [31:0] key = '0;
  logic        epoch_close = 1'b0;
  logic        report_ready = 1'b0;

  logic        sample_ready, chk_valid, chk_mismatch, report_valid;
  logic [4:0]  chk_hd;
  logic [31:0] report_key;
  logic [15:0] report_samples, report_mismatch;
  logic [23:0] report_hd;

  logic        s_sample_ready, s_chk_valid, s_chk_mismatch, s_report_valid;
  logic [4:0]  s_chk_hd;
  logic [31:0] s_report_key;
  logic [3:0]  s_report_samples, s_report_mismatch;
  logic [5:0]  s_report_hd;

  obf_corruption_monitor dut (
    .clk_i(clk), .rst_ni(rst_ni), .sample_valid_i(sample_valid), .sample_ready_o(sample_ready),
    .add1_i(add1), .add2_i(add2), .result_i(result), .key_i(key), .epoch_close_i(epoch_close),
    .chk_valid_o(chk_valid), .chk_mismatch_o(chk_mismatch), .chk_hd_o(chk_hd),
    .report_valid_o(report_valid), .report_ready_i(report_ready), .report_key_o(report_key),
    .report_samples_o(report_samples), .report_mismatch_o(report_mismatch), .report_hd_o(report_hd)
  );

  // Narrow-counter instance sharing all inputs, used for saturation.
  obf_corruption_monitor #(.CNT_W(4), .HD_W(6)) dut_small (
    .clk_i(clk), .rst_ni(rst_ni), .sample_valid_i(sample_valid), .sample_ready_o(s_sample_ready),
    .add1_i(add1), .add2_i(add2), .result_i(result), .key_i(key), .epoch_close_i(epoch_close),
    .chk_valid_o(s_chk_valid), .chk_mismatch_o(s_chk_mismatch), .chk_hd_o(s_chk_hd),
    .report_valid_o(s_report_valid), .report_ready_i(report_ready), .report_key_o(s_report_key),
    .report_samples_o(s_report_samples), .report_mismatch_o(s_report_mismatch), .report_hd_o(s_report_hd)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] a; logic [15:0] b; logic [16:0] r; logic [31:0] k; int cyc;} acc_t;
  typedef struct {logic mm; logic [4:0] hd; int cyc;} obs_t;

  acc_t acc_q[$], epoch_q[$];
  obs_t obs_q[$];
  acc_t mon_s;
  obs_t mon_o;
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;

  // Passive monitor: records accepts and check pulses mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_ni) begin
      if (sample_valid && sample_ready) begin
        mon_s = '{add1, add2, result, key, cyc};
        acc_q.push_back(mon_s);
        epoch_q.push_back(mon_s);
      end
      if (chk_valid) begin
        mon_o = '{chk_mismatch, chk_hd, cyc};
        obs_q.push_back(mon_o);
      end
    end
  end

  function automatic logic [16:0] golden(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic int hd_of(input acc_t s);
    return $countones(s.r ^ golden(s.a, s.b));
  endfunction

  task automatic model_report(input int cmax, input int hmax, output logic [31:0] k,
                              output int n, output int mm, output int hd);
    n = 0; mm = 0; hd = 0;
    k = (epoch_q.size() > 0) ? epoch_q[0].k : 32'h0;
    foreach (epoch_q[i]) begin
      n++;
      if (hd_of(epoch_q[i]) != 0) mm++;
      hd += hd_of(epoch_q[i]);
    end
    if (n > cmax) n = cmax;
    if (mm > cmax) mm = cmax;
    if (hd > hmax) hd = hmax;
  endtask

  task automatic gen(input bit corrupt, output logic [15:0] a, output logic [15:0] b, output logic [16:0] r);
    a = 16'($urandom);
    b = 16'($urandom);
    r = golden(a, b) ^ (corrupt ? (17'($urandom) | 17'h1) : 17'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; sample_valid = 1'b0; epoch_close = 1'b0; report_ready = 1'b0;
    tick(2);
    acc_q.delete(); obs_q.delete(); epoch_q.delete();
    rst_ni = 1'b1;
    tick(1);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r, input logic [31:0] k);
    bit done = 0;
    add1 = a; add2 = b; result = r; key = k; sample_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sample_ready) done = 1;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: sample key=%h never accepted, required acceptance within 100 cycles", k);
    end
  endtask

  task automatic close_epoch();
    epoch_close = 1'b1;
    tick(1);
    epoch_close = 1'b0;
  endtask

  task automatic wait_report(output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (report_valid) ok = 1;
    end
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    report_ready = 1'b1;
    tick(1);
    report_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(2);
    n_cmp++;
    if (sample_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
    n_cmp++;
    if (chk_valid !== 1'b0 || chk_mismatch !== 1'b0 || chk_hd !== 5'd0) begin
      n_err++; $display("FAIL reset_chk: got v=%b mm=%b hd=%0d want all 0", chk_valid, chk_mismatch, chk_hd);
    end
    n_cmp++;
    if (report_valid !== 1'b0 || report_key !== 32'h0 || report_samples !== 16'h0 ||
        report_mismatch !== 16'h0 || report_hd !== 24'h0) begin
      n_err++; $display("FAIL reset_report: got v=%b key=%h n=%0d mm=%0d hd=%0d want all 0",
                        report_valid, report_key, report_samples, report_mismatch, report_hd);
    end
    do_reset();
  endtask

  task automatic test_clean();
    logic [31:0] ek; int en, em, eh; bit ok;
    acc_t s; obs_t o;
    send(16'h29AF, 16'h7A1B, 17'h0A3CA, KEY_A);
    send(16'h8943, 16'hFFFF, 17'h18942, KEY_A);
    send(16'h5555, 16'hAAAA, 17'h0FFFF, KEY_A);
    tick(3);
    while (acc_q.size() > 0) begin
      s = acc_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL clean_chk: no check for a=%h, want mm=0 hd=0", s.a); end
      else begin
        o = obs_q.pop_front();
        if (o.mm !== 1'b0 || o.hd !== 5'd0 || o.cyc != s.cyc + 2)
          begin n_err++; $display("FAIL clean_chk: a=%h got mm=%b hd=%0d lat=%0d want 0 0 2", s.a, o.mm, o.hd, o.cyc - s.cyc); end
      end
    end
    close_epoch();
    wait_report(ok);
    model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
    epoch_q.delete();
    n_cmp++;
    if (!ok || report_key !== ek || report_samples !== 16'(en) || report_mismatch !== 16'(em) || report_hd !== 24'(eh)) begin
      n_err++; $display("FAIL clean_report: got v=%b key=%h n=%0d mm=%0d hd=%0d want key=%h n=%0d mm=%0d hd=%0d",
                        ok, report_key, report_samples, report_mismatch, report_hd, ek, en, em, eh);
    end
    handshake();
  endtask

  task automatic test_corrupt();
    logic [31:0] ek; int en, em, eh; bit ok;
    acc_t s; obs_t o;
    int want_hd[2] = '{1, 16};
    send(16'h29AF, 16'h7A1B, 17'h0A3CB, KEY_A);
    send(16'h5555, 16'hAAAA, 17'h00000, KEY_A);
    tick(3);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (acc_q.size() == 0 || obs_q.size() == 0) begin n_err++; $display("FAIL corrupt_chk%0d: missing, want hd=%0d", i, want_hd[i]); end
      else begin
        s = acc_q.pop_front(); o = obs_q.pop_front();
        if (o.mm !== 1'b1 || o.hd !== 5'(want_hd[i]) || o.hd !== 5'(hd_of(s)) || o.cyc != s.cyc + 2)
          begin n_err++; $display("FAIL corrupt_chk%0d: got mm=%b hd=%0d lat=%0d want 1 %0d 2", i, o.mm, o.hd, o.cyc - s.cyc, want_hd[i]); end
      end
    end
    close_epoch();
    wait_report(ok);
    model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
    epoch_q.delete();
    n_cmp++;
    if (!ok || report_key !== KEY_A || report_samples !== 16'd2 || report_mismatch !== 16'd2 ||
        report_hd !== 24'd17 || report_hd !== 24'(eh)) begin
      n_err++; $display("FAIL corrupt_report: got v=%b key=%h n=%0d mm=%0d hd=%0d want key=%h n=2 mm=2 hd=17",
                        ok, report_key, report_samples, report_mismatch, report_hd, KEY_A);
    end
    handshake();
  endtask

  task automatic test_key_change();
    logic [15:0] a, b; logic [16:0] r;
    logic [15:0] na, nb; logic [16:0] nr;
    logic [31:0] ek; int en, em, eh; bit ok; int hs_cyc;
    for (int i = 0; i < 3; i++) begin gen(i == 1, a, b, r); send(a, b, r, KEY_A); end
    gen(1, na, nb, nr);
    add1 = na; add2 = nb; result = nr; key = KEY_B; sample_valid = 1'b1;
    #1;
    n_cmp++;
    if (sample_ready !== 1'b0) begin n_err++; $display("FAIL keychg_ready: got %b want 0", sample_ready); end
    hs_cyc = 0;
    fork
      send(na, nb, nr, KEY_B);
      begin
        wait_report(ok);
        model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
        epoch_q.delete();
        n_cmp++;
        if (!ok || report_key !== KEY_A || report_samples !== 16'd3 || report_mismatch !== 16'(em) || report_hd !== 24'(eh)) begin
          n_err++; $display("FAIL keychg_report: got v=%b key=%h n=%0d mm=%0d hd=%0d want key=%h n=3 mm=%0d hd=%0d",
                            ok, report_key, report_samples, report_mismatch, report_hd, KEY_A, em, eh);
        end
        handshake();
        hs_cyc = cyc;
      end
    join
    n_cmp++;
    if (epoch_q.size() != 1 || epoch_q[0].k !== KEY_B || epoch_q[0].cyc <= hs_cyc) begin
      n_err++; $display("FAIL keychg_new_epoch: got %0d accepts (first cyc %0d) want 1 accept of key %h after cyc %0d",
                        epoch_q.size(), (epoch_q.size() > 0) ? epoch_q[0].cyc : -1, KEY_B, hs_cyc);
    end
    close_epoch();
    wait_report(ok);
    model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
    epoch_q.delete();
    n_cmp++;
    if (!ok || report_key !== KEY_B || report_samples !== 16'd1 || report_mismatch !== 16'(em) || report_hd !== 24'(eh)) begin
      n_err++; $display("FAIL keychg_report2: got v=%b key=%h n=%0d want key=%h n=1", ok, report_key, report_samples, KEY_B);
    end
    handshake();
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b; logic [16:0] r;
    logic [31:0] k1, k2, ek; int en, em, eh; bit ok;
    acc_t s; obs_t o;
    k1 = $urandom; k2 = k1 ^ 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin gen($urandom_range(0, 1) == 1, a, b, r); send(a, b, r, k1); end
    close_epoch();
    wait_report(ok);
    model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
    epoch_q.delete();
    @(posedge clk); #1;
    gen(1, a, b, r);
    add1 = a; add2 = b; result = r; key = k2; sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (!ok || report_valid !== 1'b1 || sample_ready !== 1'b0 || report_key !== ek || report_samples !== 16'(en) ||
          report_mismatch !== 16'(em) || report_hd !== 24'(eh)) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b rdy=%b key=%h n=%0d mm=%0d hd=%0d want 1 0 %h %0d %0d %0d",
                          i, report_valid, sample_ready, report_key, report_samples, report_mismatch, report_hd, ek, en, em, eh);
      end
    end
    handshake();
    send(a, b, r, k2);
    for (int i = 0; i < 7; i++) begin gen($urandom_range(0, 1) == 1, a, b, r); send(a, b, r, k2); end
    tick(3);
    n_cmp++;
    if (epoch_q.size() != 8) begin n_err++; $display("FAIL b2b_count: got %0d accepts want 8", epoch_q.size()); end
    for (int i = 1; i < epoch_q.size(); i++) begin
      n_cmp++;
      if (epoch_q[i].cyc != epoch_q[i-1].cyc + 1)
        begin n_err++; $display("FAIL b2b_gap%0d: got gap %0d want 1", i, epoch_q[i].cyc - epoch_q[i-1].cyc); end
    end
    while (acc_q.size() > 0) begin
      s = acc_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL b2b_chk: missing check for a=%h", s.a); end
      else begin
        o = obs_q.pop_front();
        if (o.mm !== (hd_of(s) != 0) || o.hd !== 5'(hd_of(s)) || o.cyc != s.cyc + 2)
          begin n_err++; $display("FAIL b2b_chk: a=%h got mm=%b hd=%0d lat=%0d want %b %0d 2", s.a, o.mm, o.hd, o.cyc - s.cyc, hd_of(s) != 0, hd_of(s)); end
      end
    end
    close_epoch();
    wait_report(ok);
    model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
    epoch_q.delete();
    n_cmp++;
    if (!ok || report_key !== k2 || report_samples !== 16'(en) || report_mismatch !== 16'(em) || report_hd !== 24'(eh)) begin
      n_err++; $display("FAIL b2b_report: got key=%h n=%0d mm=%0d hd=%0d want %h %0d %0d %0d",
                        report_key, report_samples, report_mismatch, report_hd, k2, en, em, eh);
    end
    handshake();
  endtask

  task automatic test_saturation();
    logic [15:0] a, b; logic [16:0] r;
    logic [31:0] k, ek; int en, em, eh, sn, sm, sh; bit ok;
    k = $urandom;
    for (int i = 0; i < 20; i++) begin gen(1, a, b, r); send(a, b, r, k); end
    close_epoch();
    wait_report(ok);
    model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
    model_report(S_CNT_MAX, S_HD_MAX, ek, sn, sm, sh);
    epoch_q.delete();
    n_cmp++;
    if (!ok || report_samples !== 16'd20 || report_mismatch !== 16'd20 || report_hd !== 24'(eh)) begin
      n_err++; $display("FAIL sat_wide: got n=%0d mm=%0d hd=%0d want 20 20 %0d", report_samples, report_mismatch, report_hd, eh);
    end
    n_cmp++;
    if (s_report_valid !== 1'b1 || s_report_key !== k || s_report_samples !== 4'hF ||
        s_report_mismatch !== 4'hF || s_report_hd !== 6'(sh)) begin
      n_err++; $display("FAIL sat_narrow: got v=%b n=%h mm=%h hd=%0d want 1 F F %0d",
                        s_report_valid, s_report_samples, s_report_mismatch, s_report_hd, sh);
    end
    handshake();
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [15:0] a, b; logic [16:0] r;
    logic [31:0] k, ek; int en, em, eh; bit ok;
    for (int phase = 0; phase < 2; phase++) begin
      k = $urandom;
      for (int i = 0; i < 3; i++) begin gen(1, a, b, r); send(a, b, r, k); end
      close_epoch();
      if (phase == 1) wait_report(ok);
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (sample_ready !== 1'b1 || chk_valid !== 1'b0 || report_valid !== 1'b0 || report_samples !== 16'h0 ||
          report_key !== 32'h0 || report_hd !== 24'h0 || s_report_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_mid%0d: got rdy=%b chk=%b rv=%b n=%0d key=%h hd=%0d want 1 0 0 0 0 0",
                          phase, sample_ready, chk_valid, report_valid, report_samples, report_key, report_hd);
      end
      do_reset();
      for (int i = 0; i < 2; i++) begin gen(0, a, b, r); send(a, b, r, k); end
      close_epoch();
      wait_report(ok);
      model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
      epoch_q.delete();
      n_cmp++;
      if (!ok || report_samples !== 16'd2 || report_mismatch !== 16'd0 || report_hd !== 24'd0 || report_key !== ek) begin
        n_err++; $display("FAIL reset_post%0d: got n=%0d mm=%0d hd=%0d want 2 0 0", phase, report_samples, report_mismatch, report_hd);
      end
      handshake();
    end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] a, b; logic [16:0] r;
    logic [31:0] k, ek; int en, em, eh, ns; bit ok;
    acc_t s; obs_t o;
    close_epoch();
    tick(4);
    n_cmp++;
    if (report_valid !== 1'b0 || sample_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_close: got rv=%b rdy=%b want 0 1", report_valid, sample_ready);
    end
    for (int ep = 0; ep < 4; ep++) begin
      k = $urandom;
      ns = $urandom_range(1, 12);
      for (int i = 0; i < ns; i++) begin
        gen($urandom_range(0, 1) == 1, a, b, r);
        send(a, b, r, k);
        tick($urandom_range(0, 2));
      end
      close_epoch();
      wait_report(ok);
      tick(1);
      while (acc_q.size() > 0) begin
        s = acc_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin n_err++; $display("FAIL rand_chk%0d: missing check for a=%h", ep, s.a); end
        else begin
          o = obs_q.pop_front();
          if (o.mm !== (hd_of(s) != 0) || o.hd !== 5'(hd_of(s)) || o.cyc != s.cyc + 2)
            begin n_err++; $display("FAIL rand_chk%0d: got mm=%b hd=%0d lat=%0d want %b %0d 2", ep, o.mm, o.hd, o.cyc - s.cyc, hd_of(s) != 0, hd_of(s)); end
        end
      end
      model_report(CNT_MAX, HD_MAX, ek, en, em, eh);
      epoch_q.delete();
      n_cmp++;
      if (!ok || report_key !== ek || report_samples !== 16'(en) || report_mismatch !== 16'(em) || report_hd !== 24'(eh)) begin
        n_err++; $display("FAIL rand_report%0d: got key=%h n=%0d mm=%0d hd=%0d want %h %0d %0d %0d",
                          ep, report_key, report_samples, report_mismatch, report_hd, ek, en, em, eh);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_key_change();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
